// File: rtl/cabac_pkg.sv
// Shared constants and FSM encoding for the CABAC context pipe.
package cabac_pkg;

    localparam int CTX_W       = 7;
    localparam int CTX_MPS_BIT = 6;
    localparam int CTX_NUM_DEF = 192;
    localparam int CTX_AW_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2
    } cabac_state_e;

endpackage

// File: rtl/cabac_ctx_ram.sv
// Context store: one write port, one synchronous read-first read port.
module cabac_ctx_ram
    import cabac_pkg::*;
#(
    parameter int CTX_NUM = CTX_NUM_DEF,
    parameter int CTX_AW  = CTX_AW_DEF
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [CTX_AW-1:0] i_waddr,
    input  logic [CTX_W-1:0]  i_wdata,
    input  logic              i_re,
    input  logic [CTX_AW-1:0] i_raddr,
    output logic [CTX_W-1:0]  o_rdata
);

    logic [CTX_W-1:0] r_mem [CTX_NUM];

    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
        if (i_re)
            o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/cabac_ucontext_t.sv
// CABAC context next-state function: MPS/LPS state transition.
module cabac_ucontext_t
    import cabac_pkg::*;
(
    input  logic [CTX_W-1:0] i_ctx,
    input  logic             i_bin,
    output logic [CTX_W-1:0] o_ctx
);

    logic       w_mps;
    logic [5:0] w_p;
    logic [5:0] w_lps;

    assign w_mps = i_ctx[CTX_MPS_BIT];
    assign w_p   = i_ctx[5:0];

    always_comb begin
        w_lps = 6'd0;
        case (w_p)
            6'd0:  w_lps = 6'd0;  6'd1:  w_lps = 6'd0;
            6'd2:  w_lps = 6'd1;  6'd3:  w_lps = 6'd2;
            6'd4:  w_lps = 6'd2;  6'd5:  w_lps = 6'd4;
            6'd6:  w_lps = 6'd4;  6'd7:  w_lps = 6'd5;
            6'd8:  w_lps = 6'd6;  6'd9:  w_lps = 6'd7;
            6'd10: w_lps = 6'd8;  6'd11: w_lps = 6'd9;
            6'd12: w_lps = 6'd9;  6'd13: w_lps = 6'd11;
            6'd14: w_lps = 6'd11; 6'd15: w_lps = 6'd12;
            6'd16: w_lps = 6'd13; 6'd17: w_lps = 6'd13;
            6'd18: w_lps = 6'd15; 6'd19: w_lps = 6'd15;
            6'd20: w_lps = 6'd16; 6'd21: w_lps = 6'd16;
            6'd22: w_lps = 6'd18; 6'd23: w_lps = 6'd18;
            6'd24: w_lps = 6'd19; 6'd25: w_lps = 6'd19;
            6'd26: w_lps = 6'd21; 6'd27: w_lps = 6'd21;
            6'd28: w_lps = 6'd22; 6'd29: w_lps = 6'd22;
            6'd30: w_lps = 6'd23; 6'd31: w_lps = 6'd24;
            6'd32: w_lps = 6'd24; 6'd33: w_lps = 6'd25;
            6'd34: w_lps = 6'd26; 6'd35: w_lps = 6'd26;
            6'd36: w_lps = 6'd27; 6'd37: w_lps = 6'd27;
            6'd38: w_lps = 6'd28; 6'd39: w_lps = 6'd29;
            6'd40: w_lps = 6'd29; 6'd41: w_lps = 6'd30;
            6'd42: w_lps = 6'd30; 6'd43: w_lps = 6'd30;
            6'd44: w_lps = 6'd31; 6'd45: w_lps = 6'd32;
            6'd46: w_lps = 6'd32; 6'd47: w_lps = 6'd33;
            6'd48: w_lps = 6'd33; 6'd49: w_lps = 6'd33;
            6'd50: w_lps = 6'd34; 6'd51: w_lps = 6'd34;
            6'd52: w_lps = 6'd35; 6'd53: w_lps = 6'd35;
            6'd54: w_lps = 6'd35; 6'd55: w_lps = 6'd36;
            6'd56: w_lps = 6'd36; 6'd57: w_lps = 6'd36;
            6'd58: w_lps = 6'd37; 6'd59: w_lps = 6'd37;
            6'd60: w_lps = 6'd37; 6'd61: w_lps = 6'd38;
            6'd62: w_lps = 6'd38; default: w_lps = 6'd63;
        endcase
    end

    always_comb begin
        o_ctx = i_ctx;
        if (i_bin == w_mps) begin
            if (w_p < 6'd62)
                o_ctx = {w_mps, w_p + 6'd1};
        end else begin
            // LPS in the equiprobable state swaps the MPS symbol
            o_ctx = {(w_p == 6'd0) ? ~w_mps : w_mps, w_lps};
        end
    end

endmodule

// File: rtl/cabac_context_pipe.sv
// CABAC context store with per-slice init, 2-stage read/update pipe
// and same-context forwarding.
module cabac_context_pipe
    import cabac_pkg::*;
#(
    parameter int CTX_NUM = CTX_NUM_DEF,
    parameter int CTX_AW  = CTX_AW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_start_i,
    output logic [CTX_AW-1:0] init_addr_o,
    input  logic [CTX_W-1:0]  init_ctx_i,
    output logic              init_done_o,
    input  logic              bin_valid_i,
    output logic              bin_ready_o,
    input  logic [CTX_AW-1:0] bin_ctx_idx_i,
    input  logic              bin_val_i,
    output logic              bae_valid_o,
    input  logic              bae_ready_i,
    output logic [CTX_W-1:0]  bae_ctx_o,
    output logic              bae_bin_o
);

    cabac_state_e      r_state, w_state_nxt;
    logic [CTX_AW-1:0] r_init_addr;
    logic              r_init_done;
    logic              r_s1_valid;
    logic [CTX_AW-1:0] r_s1_idx;
    logic              r_s1_bin;
    logic              r_fwd;
    logic [CTX_W-1:0]  r_fwd_ctx;
    logic              r_bae_valid;
    logic [CTX_W-1:0]  r_bae_ctx;
    logic              r_bae_bin;

    logic              w_advance, w_ready, w_accept, w_s1_fire;
    logic              w_init_last;
    logic [CTX_W-1:0]  w_rd_data, w_ctx_cur, w_ctx_upd;
    logic              w_we;
    logic [CTX_AW-1:0] w_waddr;
    logic [CTX_W-1:0]  w_wdata;

    assign w_advance   = !r_bae_valid || bae_ready_i;
    assign w_ready     = (r_state == RUN) && w_advance;
    assign w_accept    = bin_valid_i && w_ready;
    assign w_s1_fire   = r_s1_valid && w_advance;
    assign w_init_last = r_init_addr == CTX_AW'(CTX_NUM - 1);
    assign w_ctx_cur   = r_fwd ? r_fwd_ctx : w_rd_data;

    cabac_ucontext_t u_upd (
        .i_ctx (w_ctx_cur),
        .i_bin (r_s1_bin),
        .o_ctx (w_ctx_upd)
    );

    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_s1_idx;
        w_wdata = w_ctx_upd;
        // a restart cycle writes nothing, so no stale bin survives re-init
        if (!init_start_i) begin
            if (r_state == INIT) begin
                w_we    = 1'b1;
                w_waddr = r_init_addr;
                w_wdata = init_ctx_i;
            end else if (w_s1_fire) begin
                w_we    = 1'b1;
            end
        end
    end

    cabac_ctx_ram #(
        .CTX_NUM (CTX_NUM),
        .CTX_AW  (CTX_AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_re    (w_accept),
        .i_raddr (bin_ctx_idx_i),
        .o_rdata (w_rd_data)
    );

    always_comb begin
        w_state_nxt = r_state;
        if (init_start_i) begin
            w_state_nxt = INIT;
        end else begin
            unique case (r_state)
                IDLE:    w_state_nxt = IDLE;
                INIT:    w_state_nxt = w_init_last ? RUN : INIT;
                RUN:     w_state_nxt = RUN;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_init_addr <= '0;
            r_init_done <= 1'b0;
            r_s1_valid  <= 1'b0;
            r_s1_idx    <= '0;
            r_s1_bin    <= 1'b0;
            r_fwd       <= 1'b0;
            r_fwd_ctx   <= '0;
            r_bae_valid <= 1'b0;
            r_bae_ctx   <= '0;
            r_bae_bin   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (init_start_i) begin
                r_init_addr <= '0;
                r_init_done <= 1'b0;
                r_s1_valid  <= 1'b0;
                r_fwd       <= 1'b0;
                r_bae_valid <= 1'b0;
            end else begin
                if (r_state == INIT) begin
                    r_init_addr <= w_init_last ? '0 : r_init_addr + CTX_AW'(1);
                    if (w_init_last)
                        r_init_done <= 1'b1;
                end
                if (w_advance)
                    r_s1_valid <= w_accept;
                if (w_accept) begin
                    r_s1_idx  <= bin_ctx_idx_i;
                    r_s1_bin  <= bin_val_i;
                    r_fwd     <= w_s1_fire && (r_s1_idx == bin_ctx_idx_i);
                    r_fwd_ctx <= w_ctx_upd;
                end
                if (w_s1_fire) begin
                    r_bae_valid <= 1'b1;
                    r_bae_ctx   <= w_ctx_cur;
                    r_bae_bin   <= r_s1_bin;
                end else if (bae_ready_i) begin
                    r_bae_valid <= 1'b0;
                end
            end
        end
    end

    assign init_addr_o = r_init_addr;
    assign init_done_o = r_init_done;
    assign bin_ready_o = w_ready;
    assign bae_valid_o = r_bae_valid;
    assign bae_ctx_o   = r_bae_ctx;
    assign bae_bin_o   = r_bae_bin;

endmodule

// File: tb/tb_cabac_context_pipe.sv
// Bench for cabac_context_pipe: transaction-level context model,
// per-cycle compare and directed literal checks.
module tb_cabac_context_pipe;

    localparam int N = 192;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       init_start_i = 1'b0;
    logic [7:0] init_addr_o;
    logic [6:0] init_ctx_i;
    logic       init_done_o;
    logic       bin_valid_i = 1'b0;
    logic       bin_ready_o;
    logic [7:0] bin_ctx_idx_i = 8'd0;
    logic       bin_val_i = 1'b0;
    logic       bae_valid_o;
    logic       bae_ready_i = 1'b1;
    logic [6:0] bae_ctx_o;
    logic       bae_bin_o;

    logic [6:0] tab [256];
    always_comb init_ctx_i = tab[init_addr_o];

    cabac_context_pipe dut (
        .clk           (clk),
        .rst           (rst),
        .init_start_i  (init_start_i),
        .init_addr_o   (init_addr_o),
        .init_ctx_i    (init_ctx_i),
        .init_done_o   (init_done_o),
        .bin_valid_i   (bin_valid_i),
        .bin_ready_o   (bin_ready_o),
        .bin_ctx_idx_i (bin_ctx_idx_i),
        .bin_val_i     (bin_val_i),
        .bae_valid_o   (bae_valid_o),
        .bae_ready_i   (bae_ready_i),
        .bae_ctx_o     (bae_ctx_o),
        .bae_bin_o     (bae_bin_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    int lps [64] = '{
        0, 0, 1, 2, 2, 4, 4, 5, 6, 7, 8, 9, 9, 11, 11, 12,
        13, 13, 15, 15, 16, 16, 18, 18, 19, 19, 21, 21, 22, 22, 23, 24,
        24, 25, 26, 26, 27, 27, 28, 29, 29, 30, 30, 30, 31, 32, 32, 33,
        33, 33, 34, 34, 35, 35, 35, 36, 36, 36, 37, 37, 37, 38, 38, 63};

    function automatic logic [6:0] upd(input logic [6:0] c, input logic b);
        logic m;
        int   p;
        m = c[6];
        p = int'(c[5:0]);
        if (b == m) begin
            if (p < 62) p++;
        end else begin
            if (p == 0) m = ~m;
            p = lps[p];
        end
        return {m, 6'(p)};
    endfunction

    typedef struct {
        logic [6:0] ctx;
        logic       bin;
    } ob_t;

    logic [6:0] mdl [N];
    bit         m_run = 1'b0;
    int         m_cnt = 0;
    ob_t        expq [$];
    ob_t        got [$];
    ob_t        e;
    bit         p_start = 1'b0;
    bit         p_stall = 1'b0;
    logic [6:0] p_ctx;
    logic       p_bin;

    // check outputs against the model, then advance the model one edge
    always @(negedge clk) if (!rst) begin
        chk("ready", bin_ready_o, m_run && (!bae_valid_o || bae_ready_i));
        chk("done", init_done_o, m_run);
        if (p_start) begin
            chk("flush_valid", bae_valid_o, 0);
        end else if (p_stall) begin
            chk("hold_valid", bae_valid_o, 1);
            chk("hold_ctx", bae_ctx_o, p_ctx);
            chk("hold_bin", bae_bin_o, p_bin);
        end
        if (bae_valid_o && bae_ready_i) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL spurious_out: got ctx %0h want no output", bae_ctx_o);
            end else begin
                e = expq.pop_front();
                if (bae_ctx_o !== e.ctx || bae_bin_o !== e.bin) begin
                    errors++;
                    $display("FAIL out: got %0h/%0b want %0h/%0b",
                             bae_ctx_o, bae_bin_o, e.ctx, e.bin);
                end
                got.push_back('{bae_ctx_o, bae_bin_o});
            end
        end
        p_start = init_start_i;
        p_stall = bae_valid_o && !bae_ready_i;
        p_ctx   = bae_ctx_o;
        p_bin   = bae_bin_o;
        if (init_start_i) begin
            m_run = 1'b0;
            m_cnt = N;
            expq.delete();
        end else begin
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_run = 1'b1;
                    for (int i = 0; i < N; i++) mdl[i] = tab[i];
                end
            end
            if (bin_valid_i && bin_ready_o) begin
                chk("idx_range", bin_ctx_idx_i < N, 1);
                if (bin_ctx_idx_i < N) begin
                    expq.push_back('{mdl[bin_ctx_idx_i], bin_val_i});
                    mdl[bin_ctx_idx_i] = upd(mdl[bin_ctx_idx_i], bin_val_i);
                end
            end
        end
    end

    bit rnd_ready   = 1'b0;
    bit fixed_ready = 1'b1;
    always @(posedge clk) begin
        #1;
        bae_ready_i = rnd_ready ? ($urandom_range(3) != 0) : fixed_ready;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int idx, input bit b);
        int n;
        bit acc;
        n = 0;
        acc = 1'b0;
        bin_valid_i   = 1'b1;
        bin_ctx_idx_i = 8'(idx);
        bin_val_i     = b;
        while (!acc && n < 1000) begin
            @(negedge clk);
            acc = bin_ready_o;
            @(posedge clk);
            #1;
            n++;
        end
        bin_valid_i = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: idx %0d ready 0 want 1", idx);
        end
    endtask

    task automatic pulse_start();
        init_start_i = 1'b1;
        cyc(1);
        init_start_i = 1'b0;
    endtask

    task automatic wait_done(output int k);
        k = 0;
        while (!init_done_o && k < 1000) begin
            cyc(1);
            k++;
        end
        if (!init_done_o) begin
            checks++;
            errors++;
            $display("FAIL init_timeout: done 0 want 1");
        end
    endtask

    int k;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: sim time exceeded");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) tab[i] = 7'h05;
        tab[10] = 7'h00;
        tab[11] = 7'h3E;
        repeat (3) @(negedge clk);
        chk("rst_done", init_done_o, 0);
        chk("rst_addr", init_addr_o, 0);
        chk("rst_ready", bin_ready_o, 0);
        chk("rst_valid", bae_valid_o, 0);
        chk("rst_ctx", bae_ctx_o, 0);
        chk("rst_bin", bae_bin_o, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(2);

        pulse_start();
        wait_done(k);
        chk("init_len", k, 192);
        cyc(2);

        got.delete();
        send(3, 1'b1);
        @(negedge clk);
        chk("lat_n1_valid", bae_valid_o, 0);
        @(negedge clk);
        chk("lat_n2_valid", bae_valid_o, 1);
        chk("lat_n2_ctx", bae_ctx_o, 7'h05);
        cyc(3);
        send(3, 1'b0);
        cyc(4);
        chk("t2_cnt", got.size(), 2);
        if (got.size() == 2) chk("t2_second", got[1].ctx, 7'h04);

        got.delete();
        for (int i = 0; i < 4; i++) send(7, 1'b0);
        cyc(4);
        chk("t3_cnt", got.size(), 4);
        if (got.size() == 4) begin
            chk("t3_0", got[0].ctx, 7'h05);
            chk("t3_1", got[1].ctx, 7'h06);
            chk("t3_2", got[2].ctx, 7'h07);
            chk("t3_3", got[3].ctx, 7'h08);
        end

        got.delete();
        send(10, 1'b1);
        send(10, 1'b0);
        send(11, 1'b0);
        send(11, 1'b0);
        cyc(4);
        chk("t4_cnt", got.size(), 4);
        if (got.size() == 4) begin
            chk("t4_lps0", got[0].ctx, 7'h00);
            chk("t4_flip", got[1].ctx, 7'h40);
            chk("t4_sat0", got[2].ctx, 7'h3E);
            chk("t4_sat1", got[3].ctx, 7'h3E);
        end

        got.delete();
        fixed_ready = 1'b0;
        cyc(2);
        send(20, 1'b0);
        send(20, 1'b0);
        cyc(5);
        fixed_ready = 1'b1;
        cyc(4);
        send(20, 1'b0);
        cyc(4);
        chk("t5_cnt", got.size(), 3);
        if (got.size() == 3) begin
            chk("t5_0", got[0].ctx, 7'h05);
            chk("t5_1", got[1].ctx, 7'h06);
            chk("t5_2", got[2].ctx, 7'h07);
        end

        fixed_ready = 1'b0;
        cyc(2);
        send(30, 1'b0);
        send(31, 1'b1);
        @(negedge clk);
        chk("t6_pre_valid", bae_valid_o, 1);
        cyc(1);
        for (int i = 0; i < 256; i++) tab[i] = 7'h2A;
        pulse_start();
        wait_done(k);
        fixed_ready = 1'b1;
        cyc(3);
        got.delete();
        for (int i = 0; i < N; i++) send(i, 1'($urandom_range(1)));
        cyc(4);
        chk("t6_cnt", got.size(), N);
        if (got.size() == N) begin
            chk("t6_c30", got[30].ctx, 7'h2A);
            chk("t6_c31", got[31].ctx, 7'h2A);
            chk("t6_c191", got[191].ctx, 7'h2A);
        end

        for (int i = 0; i < 256; i++)
            tab[i] = {1'($urandom_range(1)), 6'($urandom_range(62))};
        pulse_start();
        wait_done(k);
        rnd_ready = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            if (i == 1200) begin
                pulse_start();
                cyc(50);
                pulse_start();
                wait_done(k);
            end
            if ($urandom_range(1) == 0)
                send($urandom_range(3), 1'($urandom_range(1)));
            else
                send($urandom_range(N - 1), 1'($urandom_range(1)));
            if ($urandom_range(7) == 0) cyc($urandom_range(3));
        end
        rnd_ready = 1'b0;
        fixed_ready = 1'b1;
        cyc(6);
        chk("drain", expq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cabac_context_pipe.md
Name: cabac_context_pipe

Overview:
- Context-state store and update pipeline for the CABAC encoder.
- Accepts context-coded bin requests of the form (ctx_idx, bin).
- For each request, reads the 7-bit context {mps, pStateIdx} and passes the pre-update context plus the bin downstream to the binary arithmetic encoder.
- Writes the updated context back through the existing cabac_ucontext_t next-state logic.
- Owns per-slice context initialisation and read-after-write forwarding for back-to-back bins on the same context.

Parameters:
- CTX_NUM, 192, number of context entries.
- CTX_AW, 8, context index width; requires 2^CTX_AW >= CTX_NUM.

Ports:
- clk, input, 1, clock.
- rst, input, 1, asynchronous active-high reset.
- init_start_i, input, 1, pulse that starts context initialisation.
- init_addr_o, output, CTX_AW, index currently being initialised.
- init_ctx_i, input, 7, init value for init_addr_o, driven combinationally by the external init ROM.
- init_done_o, output, 1, high once initialisation is complete; cleared by init_start_i.
- bin_valid_i, input, 1, bin request valid.
- bin_ready_o, output, 1, pipe accepts a request this cycle.
- bin_ctx_idx_i, input, CTX_AW, context index of the request.
- bin_val_i, input, 1, bin value.
- bae_valid_o, output, 1, output valid.
- bae_ready_i, input, 1, downstream accepts output.
- bae_ctx_o, output, 7, pre-update context {mps, pStateIdx}.
- bae_bin_o, output, 1, bin value.

Behaviour:
- Clock and reset: single clock domain, clk. Reset rst is asynchronous and active-high.
- Reset values: state = IDLE; init_done_o = 0; init_addr_o = 0; bin_ready_o = 0; bae_valid_o = 0; bae_ctx_o = 0; bae_bin_o = 0. Context array contents are not reset.
- FSM states: IDLE, INIT, RUN.
  - IDLE: on init_start_i go to INIT.
  - INIT: each cycle write init_ctx_i to entry init_addr_o, then increment init_addr_o.
  - INIT exit: after writing entry CTX_NUM-1, go to RUN, set init_done_o = 1 and return init_addr_o to 0. INIT therefore takes exactly CTX_NUM cycles.
  - RUN: on init_start_i go to INIT.
- init_start_i in any state, including mid-INIT or mid-RUN:
  - restart at address 0;
  - clear init_done_o;
  - flush S1 and the output register (bae_valid_o = 0 next cycle; in-flight bins are discarded).
- Storage: synchronous-read array with read-first semantics.
  - The read address is registered on accept.
  - Read data is valid in S1.
- Handshakes:
  - advance = !bae_valid_o || bae_ready_i.
  - bin_ready_o = (state == RUN) && advance.
  - accept = bin_valid_i && bin_ready_o.
- Pipeline:
  - S0: on accept, issue the array read and capture idx and bin into S1.
  - S1: when valid and advance:
    - ctx_cur = forward-reg if the forward flag is set, else the array read data;
    - write cabac_ucontext_t(ctx_cur, bin) to idx;
    - load bae_ctx_o = ctx_cur, bae_bin_o = bin, bae_valid_o = 1.
  - If S1 is valid but advance = 0: S1 holds, no write-back occurs, and the array output is held (read enable low).
  - bae_valid_o clears when bae_ready_i = 1 and S1 is not advancing.
- Latency: a request accepted on cycle N gives bae_valid_o = 1 on cycle N+2. Throughput is 1 bin/cycle when bae_ready_i = 1.
- Forwarding rule:
  - On accept, if S1 is valid and advancing and S1.idx == bin_ctx_idx_i, set the forward flag and latch the updated context into the forward register.
  - Otherwise clear the forward flag.
  - This covers any run length of same-index bins.
- Index range: indices >= CTX_NUM are illegal; no protection is provided, and the behaviour is an assertion target for verification.
- Context update: saturation at pStateIdx 62 and the MPS flip at state 0 are inherited unchanged from cabac_ucontext_t.

Decomposition:
- Shared package cabac_pkg:
  - context width = 7;
  - MPS bit position = 6;
  - FSM state encodings IDLE / INIT / RUN;
  - CTX_NUM / CTX_AW defaults.
- Sub-module cabac_ctx_ram: CTX_NUM x 7 synchronous-read, read-first array, with one write port and one read port.
- cabac_ucontext_t is instantiated unchanged as the combinational update function.

Test Plan:
1. Init with CTX_NUM = 192, init_ctx_i = 7'h05 for all entries -> init_done_o rises exactly 192 cycles after init_start_i; bin_ready_o = 0 throughout.
2. Single bin on ctx 3 (value 7'h05), bin 1 (LPS), bae_ready_i = 1 -> bae_ctx_o = 7'h05 at N+2; a later bin on ctx 3 sees 7'h04.
3. Four back-to-back bins, value 0, on ctx 7 (value 7'h05), full rate -> bae_ctx_o sequence 7'h05, 7'h06, 7'h07, 7'h08, which exercises forwarding.
4. Ctx initialised to 7'h00, bin 1 -> output 7'h00; the next same-ctx bin sees 7'h40 (MPS flip). Ctx initialised to 7'h3E, bin 0 -> it stays 7'h3E.
5. bae_ready_i held low for 5 cycles with 2 bins queued on the same ctx -> outputs hold stable, exactly one write-back per bin, and values are correct once released.
6. init_start_i asserted while bae_valid_o = 1 and S1 is valid -> bae_valid_o = 0 next cycle, no stale write lands after re-init, and all entries equal the new init value.
